apbarbiter: RTL

Single-clock APB arbiter. It shares one downstream APB slave, typically the slave port of the APB clock-crossing bridge or a peripheral bus, between NM upstream APB masters. Grants are round-robin, and there is one transfer in flight at a time. All downstream request signals are registered from the granted port.

---
 rtl/apbarbiter_if.sv | 51 +++++
 rtl/apbarbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/apbarbiter_if.sv
// Upstream (NM masters) and downstream (one slave) APB signal bundle for apbarbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface apbarbiter_if #(
    parameter int NM               = 2,
    parameter int C_APB_ADDR_WIDTH = 12,
    parameter int C_APB_DATA_WIDTH = 32
);
    localparam int AW = C_APB_ADDR_WIDTH;
    localparam int DW = C_APB_DATA_WIDTH;
    localparam int SW = C_APB_DATA_WIDTH / 8;

    logic [NM-1:0]      S_APB_PSEL;
    logic [NM-1:0]      S_APB_PENABLE;
    logic [NM-1:0]      S_APB_PREADY;
    logic [NM*AW-1:0]   S_APB_PADDR;
    logic [NM-1:0]      S_APB_PWRITE;
    logic [NM*DW-1:0]   S_APB_PWDATA;
    logic [NM*SW-1:0]   S_APB_PWSTRB;
    logic [NM*3-1:0]    S_APB_PPROT;
    logic [DW-1:0]      S_APB_PRDATA;
    logic [NM-1:0]      S_APB_PSLVERR;

    logic               M_APB_PSEL;
    logic               M_APB_PENABLE;
    logic               M_APB_PREADY;
    logic [AW-1:0]      M_APB_PADDR;
    logic               M_APB_PWRITE;
    logic [DW-1:0]      M_APB_PWDATA;
    logic [SW-1:0]      M_APB_PWSTRB;
    logic [2:0]         M_APB_PPROT;
    logic [DW-1:0]      M_APB_PRDATA;
    logic               M_APB_PSLVERR;

    modport slave (
        input  S_APB_PSEL, S_APB_PENABLE, S_APB_PADDR, S_APB_PWRITE,
               S_APB_PWDATA, S_APB_PWSTRB, S_APB_PPROT,
        output S_APB_PREADY, S_APB_PRDATA, S_APB_PSLVERR,
        output M_APB_PSEL, M_APB_PENABLE, M_APB_PADDR, M_APB_PWRITE,
               M_APB_PWDATA, M_APB_PWSTRB, M_APB_PPROT,
        input  M_APB_PREADY, M_APB_PRDATA, M_APB_PSLVERR
    );

    modport master (
        output S_APB_PSEL, S_APB_PENABLE, S_APB_PADDR, S_APB_PWRITE,
               S_APB_PWDATA, S_APB_PWSTRB, S_APB_PPROT,
        input  S_APB_PREADY, S_APB_PRDATA, S_APB_PSLVERR,
        input  M_APB_PSEL, M_APB_PENABLE, M_APB_PADDR, M_APB_PWRITE,
               M_APB_PWDATA, M_APB_PWSTRB, M_APB_PPROT,
        output M_APB_PREADY, M_APB_PRDATA, M_APB_PSLVERR
    );
endinterface

// File: rtl/apbarbiter.sv
// Round-robin arbiter sharing one APB slave among NM masters; request to PREADY is 3+W cycles.
// One transfer in flight: other masters simply wait with PSEL high until granted in IDLE.
module apbarbiter #(
    parameter int NM               = 2,
    parameter int C_APB_ADDR_WIDTH = 12,
    parameter int C_APB_DATA_WIDTH = 32,
    parameter bit OPT_LOWPOWER     = 1'b0
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    apbarbiter_if.slave apb
);
    localparam int AW = C_APB_ADDR_WIDTH;
    localparam int DW = C_APB_DATA_WIDTH;
    localparam int SW = C_APB_DATA_WIDTH / 8;
    localparam int GW = $clog2(NM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state_q,   state_d;
    logic [GW-1:0]   grant_q,   grant_d;
    logic [GW-1:0]   last_q,    last_d;
    logic            psel_q,    psel_d;
    logic            penable_q, penable_d;
    logic [AW-1:0]   paddr_q,   paddr_d;
    logic            pwrite_q,  pwrite_d;
    logic [DW-1:0]   pwdata_q,  pwdata_d;
    logic [SW-1:0]   pwstrb_q,  pwstrb_d;
    logic [2:0]      pprot_q,   pprot_d;
    logic [DW-1:0]   prdata_q,  prdata_d;
    logic            pslverr_q, pslverr_d;
    logic [NM-1:0]   pready_q,  pready_d;

    logic            req_found;
    logic [GW-1:0]   req_pick;
    logic [GW-1:0]   req_cand;

    // Upstream PENABLE carries no information for arbitration: any selected master is a request.
    logic            unused_penable;
    assign unused_penable = |apb.S_APB_PENABLE;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pwstrb_d  = pwstrb_q;
        pprot_d   = pprot_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        pready_d  = '0;

        // Search upward from the port after the last winner, wrapping, so the last winner ranks lowest.
        req_found = 1'b0;
        req_pick  = '0;
        req_cand  = '0;
        for (int i = 1; i <= NM; i++) begin
            req_cand = GW'((int'(last_q) + i) % NM);
            if (!req_found && apb.S_APB_PSEL[req_cand]) begin
                req_found = 1'b1;
                req_pick  = req_cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d  = SETUP;
                    grant_d  = req_pick;
                    last_d   = req_pick;
                    psel_d   = 1'b1;
                    pwrite_d = apb.S_APB_PWRITE[req_pick];
                    for (int p = 0; p < NM; p++) begin
                        if (req_pick == GW'(p)) begin
                            paddr_d  = apb.S_APB_PADDR[p*AW +: AW];
                            pwdata_d = apb.S_APB_PWDATA[p*DW +: DW];
                            pwstrb_d = apb.S_APB_PWSTRB[p*SW +: SW];
                            pprot_d  = apb.S_APB_PPROT[p*3 +: 3];
                        end
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (apb.M_APB_PREADY) begin
                    state_d            = RESP;
                    psel_d             = 1'b0;
                    penable_d          = 1'b0;
                    prdata_d           = apb.M_APB_PRDATA;
                    pslverr_d          = apb.M_APB_PSLVERR;
                    pready_d[grant_q]  = 1'b1;
                    if (OPT_LOWPOWER) begin
                        paddr_d  = '0;
                        pwrite_d = 1'b0;
                        pwdata_d = '0;
                        pwstrb_d = '0;
                        pprot_d  = '0;
                    end
                end
            end
            RESP: begin
                // Granted master still holds PSEL this cycle, so no arbitration here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NM - 1);
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pwstrb_q  <= '0;
            pprot_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            pready_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pwstrb_q  <= pwstrb_d;
            pprot_q   <= pprot_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            pready_q  <= pready_d;
        end
    end

    assign apb.M_APB_PSEL    = psel_q;
    assign apb.M_APB_PENABLE = penable_q;
    assign apb.M_APB_PADDR   = paddr_q;
    assign apb.M_APB_PWRITE  = pwrite_q;
    assign apb.M_APB_PWDATA  = pwdata_q;
    assign apb.M_APB_PWSTRB  = pwstrb_q;
    assign apb.M_APB_PPROT   = pprot_q;

    assign apb.S_APB_PREADY  = pready_q;
    assign apb.S_APB_PSLVERR = {NM{pslverr_q}} & pready_q;
    assign apb.S_APB_PRDATA  = (OPT_LOWPOWER && !(|pready_q)) ? '0 : prdata_q;
endmodule
